// File: rtl/fetch_exec_sequencer_if.sv
// Memory-read and core-handshake bundle between the fetch/execute
// sequencer (master) and the instruction memory / core pair (slave).
interface fetch_exec_sequencer_if #(
  parameter int AW = 8,
  parameter int IW = 16
);
  logic          mem_re;
  logic [AW-1:0] mem_addr;
  logic [IW-1:0] mem_rdata;
  logic          core_run;
  logic [IW-1:0] core_instr;
  logic          core_done;
  logic          branch_taken;
  logic [AW-1:0] branch_target;

  modport master (
    output mem_re, mem_addr, core_run, core_instr,
    input  mem_rdata, core_done, branch_taken, branch_target
  );

  modport slave (
    input  mem_re, mem_addr, core_run, core_instr,
    output mem_rdata, core_done, branch_taken, branch_target
  );
endinterface

// File: rtl/fetch_exec_sequencer.sv
// Fetch/execute sequencer: owns the PC, reads instructions from a
// fixed-latency synchronous memory, hands them to the core, applies
// branch results, detects the halt opcode and watches for a stuck core.
// Build option FSEQ_STEP_EN adds step_mode/step_req single-step control.
module fetch_exec_sequencer #(
  parameter int            AW          = 8,
  parameter int            IW          = 16,
  parameter int            MEM_LAT     = 1,
  parameter int            TIMEOUT     = 64,
  parameter logic [AW-1:0] RESET_PC    = '0,
  parameter logic [IW-1:0] HALT_OPCODE = '1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  fetch_exec_sequencer_if.master bus,
  output logic [AW-1:0]         pc,
  output logic [15:0]           instr_count,
  output logic                  busy,
  output logic                  halt,
  output logic                  timeout_err
`ifdef FSEQ_STEP_EN
  ,
  input  logic                  step_mode,
  input  logic                  step_req
`endif
);

  localparam int WCW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int ECW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_DECODE, S_EXEC, S_UPDATE, S_HALT, S_ERR
  } state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  pc_q, pc_d;
  logic [IW-1:0]  instr_q, instr_d;
  logic [15:0]    cnt_q, cnt_d;
  logic [WCW-1:0] wait_q, wait_d;
  logic [ECW-1:0] exec_q, exec_d;
  logic           done_pend_q, done_pend_d;
  logic           br_taken_q, br_taken_d;
  logic [AW-1:0]  br_target_q, br_target_d;
  logic           start_ok;
  logic           step_stop;

`ifdef FSEQ_STEP_EN
  assign start_ok  = !step_mode || step_req;
  assign step_stop = step_mode;
`else
  assign start_ok  = 1'b1;
  assign step_stop = 1'b0;
`endif

  // State and datapath registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      instr_q     <= '0;
      cnt_q       <= '0;
      wait_q      <= '0;
      exec_q      <= '0;
      done_pend_q <= 1'b0;
      br_taken_q  <= 1'b0;
      br_target_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
      exec_q      <= exec_d;
      done_pend_q <= done_pend_d;
      br_taken_q  <= br_taken_d;
      br_target_q <= br_target_d;
    end
  end

  // Next-state logic; run=0 freezes everything except capturing a done
  // that the core raises while the sequencer is paused in EXEC.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    cnt_d       = cnt_q;
    wait_d      = wait_q;
    exec_d      = exec_q;
    done_pend_d = done_pend_q;
    br_taken_d  = br_taken_q;
    br_target_d = br_target_q;
    if (run) begin
      case (state_q)
        S_IDLE:   if (start_ok) state_d = S_FETCH;
        S_FETCH: begin
          state_d = S_WAIT;
          wait_d  = '0;
        end
        S_WAIT: begin
          if (wait_q == WCW'(MEM_LAT - 1)) begin
            instr_d = bus.mem_rdata;
            wait_d  = '0;
            state_d = S_DECODE;
          end else begin
            wait_d = wait_q + WCW'(1);
          end
        end
        S_DECODE: begin
          if (instr_q == HALT_OPCODE) begin
            state_d = S_HALT;
          end else begin
            state_d = S_EXEC;
            exec_d  = '0;
          end
        end
        S_EXEC: begin
          if (done_pend_q) begin
            // branch inputs were captured when the paused done arrived
            done_pend_d = 1'b0;
            state_d     = S_UPDATE;
          end else if (bus.core_done) begin
            br_taken_d  = bus.branch_taken;
            br_target_d = bus.branch_target;
            state_d     = S_UPDATE;
          end else if (exec_q == ECW'(TIMEOUT - 1)) begin
            state_d = S_ERR;
          end else begin
            exec_d = exec_q + ECW'(1);
          end
        end
        S_UPDATE: begin
          pc_d    = br_taken_q ? br_target_q : pc_q + AW'(1);
          cnt_d   = cnt_q + 16'd1;
          state_d = step_stop ? S_IDLE : S_FETCH;
        end
        default: ;
      endcase
    end else if (state_q == S_EXEC && bus.core_done && !done_pend_q) begin
      done_pend_d = 1'b1;
      br_taken_d  = bus.branch_taken;
      br_target_d = bus.branch_target;
    end
  end

  assign bus.mem_re     = (state_q == S_FETCH);
  assign bus.mem_addr   = pc_q;
  assign bus.core_run   = (state_q == S_EXEC);
  assign bus.core_instr = instr_q;
  assign pc             = pc_q;
  assign instr_count    = cnt_q;
  assign busy           = !(state_q == S_IDLE || state_q == S_HALT || state_q == S_ERR);
  assign halt           = (state_q == S_HALT);
  assign timeout_err    = (state_q == S_ERR);

endmodule

// File: tb/tb_fetch_exec_sequencer.sv
// Bench for fetch_exec_sequencer. Two instances (MEM_LAT=1/RESET_PC=0 and
// MEM_LAT=3/RESET_PC=0xFF, both TIMEOUT=8) share stimulus; the idle one is
// held in reset and outputs are observed through a selector.
module tb_fetch_exec_sequencer;

  logic        clk = 1'b0;
  logic        rst, run, core_done, br_tk;
  logic [7:0]  br_tgt;
  logic        sel;
  int          ml;
  logic [7:0]  rpc;
`ifdef FSEQ_STEP_EN
  logic        step_mode, step_req;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [15:0] mem [256];
  logic [16:0] p0 = '0, p1a = '0, p1b = '0, p1c = '0;

  logic [7:0]  pc0, pc1;
  logic [15:0] cnt0, cnt1;
  logic        busy0, busy1, halt0, halt1, terr0, terr1;
  logic        rst0, rst1;

  fetch_exec_sequencer_if #(.AW(8), .IW(16)) bus0 ();
  fetch_exec_sequencer_if #(.AW(8), .IW(16)) bus1 ();

  assign rst0 = rst | sel;
  assign rst1 = rst | ~sel;
  assign bus0.core_done = core_done;  assign bus1.core_done = core_done;
  assign bus0.branch_taken = br_tk;   assign bus1.branch_taken = br_tk;
  assign bus0.branch_target = br_tgt; assign bus1.branch_target = br_tgt;

  fetch_exec_sequencer #(.AW(8), .IW(16), .MEM_LAT(1), .TIMEOUT(8),
                         .RESET_PC(8'h00), .HALT_OPCODE(16'hFFFF)) dut0 (
    .clk(clk), .reset(rst0), .run(run), .bus(bus0), .pc(pc0),
    .instr_count(cnt0), .busy(busy0), .halt(halt0), .timeout_err(terr0)
`ifdef FSEQ_STEP_EN
    , .step_mode(step_mode), .step_req(step_req)
`endif
  );

  fetch_exec_sequencer #(.AW(8), .IW(16), .MEM_LAT(3), .TIMEOUT(8),
                         .RESET_PC(8'hFF), .HALT_OPCODE(16'hFFFF)) dut1 (
    .clk(clk), .reset(rst1), .run(run), .bus(bus1), .pc(pc1),
    .instr_count(cnt1), .busy(busy1), .halt(halt1), .timeout_err(terr1)
`ifdef FSEQ_STEP_EN
    , .step_mode(step_mode), .step_req(step_req)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // memory: data valid exactly MEM_LAT cycles after a read strobe, junk otherwise
  always @(posedge clk) begin
    p0  <= {bus0.mem_re, mem[bus0.mem_addr]};
    p1a <= {bus1.mem_re, mem[bus1.mem_addr]};
    p1b <= p1a;
    p1c <= p1b;
  end
  assign bus0.mem_rdata = p0[16]  ? p0[15:0]  : 16'h0BAD;
  assign bus1.mem_rdata = p1c[16] ? p1c[15:0] : 16'h0BAD;

  logic        o_re, o_run, o_busy, o_halt, o_terr;
  logic [7:0]  o_addr, o_pc;
  logic [15:0] o_instr, o_cnt;
  assign o_re    = sel ? bus1.mem_re     : bus0.mem_re;
  assign o_run   = sel ? bus1.core_run   : bus0.core_run;
  assign o_addr  = sel ? bus1.mem_addr   : bus0.mem_addr;
  assign o_instr = sel ? bus1.core_instr : bus0.core_instr;
  assign o_pc    = sel ? pc1    : pc0;
  assign o_cnt   = sel ? cnt1   : cnt0;
  assign o_busy  = sel ? busy1  : busy0;
  assign o_halt  = sel ? halt1  : halt0;
  assign o_terr  = sel ? terr1  : terr0;

  // reference model state: architectural PC/count and the cycle the next fetch is due
  logic [7:0]  exp_pc;
  logic [15:0] exp_cnt;
  int          exp_fetch;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL cfg%0d %s: got %0h expected %0h", sel, tag, got, exp);
    end
  endtask

  task automatic do_reset(input bit noisy);
    rst = 1'b1; run = 1'b1; core_done = noisy; br_tk = noisy;
    @(negedge clk);
    core_done = 1'b0;
    @(negedge clk);
    chk("rst_pc", 32'(o_pc), 32'(rpc));
    chk("rst_cnt", 32'(o_cnt), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_halt", 32'(o_halt), 0);
    chk("rst_terr", 32'(o_terr), 0);
    chk("rst_mem_re", 32'(o_re), 0);
    chk("rst_core_run", 32'(o_run), 0);
    chk("rst_instr", 32'(o_instr), 0);
    rst = 1'b0;
    exp_pc = rpc; exp_cnt = 16'd0; exp_fetch = cyc + 1;
  endtask

  task automatic wait_fetch();
    int n = 0;
    while (!o_re && n < 30) begin @(negedge clk); n++; end
    chk("fetch_seen", 32'(o_re), 1);
    chk("fetch_cyc", cyc, exp_fetch);
    chk("mem_addr", 32'(o_addr), 32'(exp_pc));
    chk("pc", 32'(o_pc), 32'(exp_pc));
    chk("instr_count", 32'(o_cnt), 32'(exp_cnt));
  endtask

  // one full instruction: fetch, execute with a core done after dly cycles,
  // optionally with run dropped for 4 cycles as the done arrives
  task automatic do_instr(input int dly, input bit tk, input logic [7:0] tgt, input bit drop);
    int t0, n;
    wait_fetch();
    t0 = cyc; n = 0;
    while (!o_run && n < 30) begin @(negedge clk); n++; end
    chk("exec_lat", cyc - t0, ml + 2);
    chk("core_instr", 32'(o_instr), 32'(mem[exp_pc]));
    chk("busy", 32'(o_busy), 1);
    repeat (dly) @(negedge clk);
    chk("run_held", 32'(o_run), 1);
    core_done = 1'b1; br_tk = tk; br_tgt = tgt;
    if (drop) begin
      run = 1'b0;
      @(negedge clk);
      core_done = 1'b0; br_tk = ~tk; br_tgt = ~tgt;
      repeat (3) @(negedge clk);
      chk("frozen_run", 32'(o_run), 1);
      chk("frozen_pc", 32'(o_pc), 32'(exp_pc));
      chk("frozen_cnt", 32'(o_cnt), 32'(exp_cnt));
      run = 1'b1;
    end
    exp_fetch = cyc + 2;
    @(negedge clk);
    core_done = 1'b0; br_tk = 1'($urandom); br_tgt = 8'($urandom);
    chk("update_no_run", 32'(o_run), 0);
    exp_pc  = tk ? tgt : 8'(exp_pc + 8'd1);
    exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic do_halt();
    int t0, n;
    bit seen, re_seen;
    logic [15:0] saved;
    logic [7:0]  hp;
    hp = exp_pc; saved = mem[hp]; mem[hp] = 16'hFFFF;
    wait_fetch();
    t0 = cyc; n = 0; seen = 1'b0;
    while (!o_halt && n < 30) begin
      if (o_run) seen = 1'b1;
      @(negedge clk); n++;
    end
    chk("halt_lat", cyc - t0, ml + 2);
    chk("halt_never_run", 32'(seen), 0);
    chk("halt_busy", 32'(o_busy), 0);
    chk("halt_pc", 32'(o_pc), 32'(hp));
    re_seen = 1'b0;
    repeat (6) begin
      core_done = 1'($urandom);
      @(negedge clk);
      if (o_re || o_run) re_seen = 1'b1;
    end
    core_done = 1'b0;
    chk("halt_sticky", 32'(o_halt), 1);
    chk("halt_quiet", 32'(re_seen), 0);
    chk("halt_pc_hold", 32'(o_pc), 32'(hp));
    chk("halt_cnt_hold", 32'(o_cnt), 32'(exp_cnt));
    mem[hp] = saved;
  endtask

  task automatic do_timeout();
    int t0, n;
    do_reset(1'b0);
    wait_fetch();
    n = 0;
    while (!o_run && n < 30) begin @(negedge clk); n++; end
    t0 = cyc; n = 0;
    while (!o_terr && n < 40) begin @(negedge clk); n++; end
    chk("timeout_lat", cyc - t0, 8);
    chk("timeout_run_off", 32'(o_run), 0);
    chk("timeout_busy", 32'(o_busy), 0);
    chk("timeout_pc", 32'(o_pc), 32'(rpc));
    repeat (3) @(negedge clk);
    chk("timeout_sticky", 32'(o_terr), 1);
  endtask

`ifdef FSEQ_STEP_EN
  task automatic do_step();
    bit seen;
    step_mode = 1'b1; step_req = 1'b0;
    do_reset(1'b0);
    repeat (3) begin
      seen = 1'b0;
      repeat (4) begin
        if (o_re || o_busy) seen = 1'b1;
        @(negedge clk);
      end
      chk("step_idle", 32'(seen), 0);
      step_req = 1'b1; exp_fetch = cyc + 1;
      @(negedge clk);
      step_req = 1'b0;
      do_instr(int'($urandom_range(0, 2)), 1'b0, 8'h00, 1'b0);
      @(negedge clk);
      chk("step_back_idle", 32'(o_busy), 0);
    end
    chk("step_cnt", 32'(o_cnt), 32'(exp_cnt));
    step_mode = 1'b0;
  endtask
`endif

  task automatic run_cfg();
    logic [7:0] a;
    int n;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom_range(0, 16'hFFFE));
    a = rpc;
    mem[a] = 16'h1111; a = a + 8'd1;
    mem[a] = 16'h2222; a = a + 8'd1;
    mem[a] = 16'h3333; a = a + 8'd1;
    mem[a] = 16'h0001;
    do_reset(1'b0);
    n = 0;
    while (!o_run && n < 30) begin @(negedge clk); n++; end
    chk("pre_abort_exec", 32'(o_run), 1);
    do_reset(1'b1);
    do_instr(1, 1'b0, 8'h00, 1'b0);
    do_instr(1, 1'b0, 8'h00, 1'b0);
    do_instr(1, 1'b0, 8'h00, 1'b0);
    do_instr(1, 1'b1, 8'h40, 1'b0);
    for (int i = 0; i < 16; i++)
      do_instr(int'($urandom_range(0, 3)), $urandom_range(0, 2) == 0,
               8'($urandom), (i == 2) || ($urandom_range(0, 4) == 0));
    do_halt();
    do_timeout();
`ifdef FSEQ_STEP_EN
    do_step();
`endif
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; core_done = 1'b0; br_tk = 1'b0; br_tgt = 8'h00;
    sel = 1'b0; ml = 1; rpc = 8'h00;
    exp_pc = 8'h00; exp_cnt = 16'd0; exp_fetch = 0;
`ifdef FSEQ_STEP_EN
    step_mode = 1'b0; step_req = 1'b0;
`endif
    for (int c = 0; c < 2; c++) begin
      sel = (c != 0);
      ml  = (c != 0) ? 3 : 1;
      rpc = (c != 0) ? 8'hFF : 8'h00;
      run_cfg();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
